// File: rtl/demux_frame_collector.sv
// Reassembles the per-lane bits of a 1:LANES select demux into one frame,
// handing it downstream on a valid/ready handshake or flushing a partial frame after an idle timeout.
module demux_frame_collector #(
    parameter int LANES   = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [LANES-1:0] lane_in,
    output logic             in_ready,
    output logic [LANES-1:0] frame_data,
    output logic [LANES-1:0] frame_mask,
    output logic             frame_partial,
    output logic             frame_valid,
    input  logic             frame_ready,
    input  logic             err_clr,
    output logic             err_mismatch,
    output logic             err_dup,
    output logic             err_overflow
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    function automatic logic [LANES-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [LANES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [LANES-1:0] r_data;
    logic [LANES-1:0] r_mask;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_valid;
    logic             r_partial;
    logic             r_err_mismatch;
    logic             r_err_dup;
    logic             r_err_overflow;

    logic             w_accept;
    logic [LANES-1:0] w_onehot;
    logic [LANES-1:0] w_mask_wr;
    logic             w_set_partial;
    logic             w_handshake;

    assign w_onehot    = onehot(in_sel);
    assign w_mask_wr   = r_mask | w_onehot;
    assign w_accept    = in_valid & ~r_valid;
    assign w_handshake = r_valid & frame_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a write arriving in the expiry cycle takes priority over the flush
    always_comb begin
        w_state_next  = r_state;
        w_set_partial = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (&w_mask_wr) ? S_HOLD : S_COLLECT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_state_next = (&w_mask_wr) ? S_HOLD : S_COLLECT;
                end else if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next  = S_HOLD;
                    w_set_partial = 1'b1;
                end else begin
                    w_state_next = S_COLLECT;
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath, idle counter and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_mask     <= '0;
            r_idle_cnt <= '0;
            r_valid    <= 1'b0;
            r_partial  <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_data     <= '0;
                r_mask     <= '0;
                r_idle_cnt <= '0;
                r_partial  <= 1'b0;
            end else if (w_accept) begin
                r_data[in_sel] <= lane_in[in_sel];
                r_mask         <= w_mask_wr;
                r_idle_cnt     <= '0;
            end else if (r_state == S_COLLECT && w_state_next == S_COLLECT) begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end else begin
                r_idle_cnt <= r_idle_cnt;
            end
            if (w_set_partial) begin
                r_partial <= 1'b1;
            end
            r_valid <= (w_state_next == S_HOLD);
        end
    end

    // Sticky error flags; a new error in the clear cycle wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_mismatch <= 1'b0;
            r_err_dup      <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_mismatch <= (r_err_mismatch & ~err_clr) | (w_accept & (|(lane_in & ~w_onehot)));
            r_err_dup      <= (r_err_dup & ~err_clr) | (w_accept & (|(r_mask & w_onehot)));
            r_err_overflow <= (r_err_overflow & ~err_clr) | (in_valid & r_valid);
        end
    end

    assign in_ready      = ~r_valid;
    assign frame_valid   = r_valid;
    assign frame_data    = r_data;
    assign frame_mask    = r_mask;
    assign frame_partial = r_partial;
    assign err_mismatch  = r_err_mismatch;
    assign err_dup       = r_err_dup;
    assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_demux_frame_collector.sv
// Scoreboard bench for demux_frame_collector: expected frames are queued at stimulus time
// and compared (contents and arrival cycle) when frame_valid rises.
module tb_demux_frame_collector;

    typedef struct {
        logic [7:0] data;
        logic [7:0] mask;
        logic       partial;
        int         cyc;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [7:0] lane_in;
    logic       in_ready;
    logic [7:0] frame_data;
    logic [7:0] frame_mask;
    logic       frame_partial;
    logic       frame_valid;
    logic       frame_ready;
    logic       err_clr;
    logic       err_mismatch;
    logic       err_dup;
    logic       err_overflow;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    logic   prev_valid = 1'b0;
    frame_t sb_q[$];

    demux_frame_collector #(.LANES(8), .SEL_W(3), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_sel        (in_sel),
        .lane_in       (lane_in),
        .in_ready      (in_ready),
        .frame_data    (frame_data),
        .frame_mask    (frame_mask),
        .frame_partial (frame_partial),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .err_clr       (err_clr),
        .err_mismatch  (err_mismatch),
        .err_dup       (err_dup),
        .err_overflow  (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on each new frame
    always @(negedge clk) begin
        if (frame_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_frame", 32'd1, 32'd0);
            end else begin
                frame_t e;
                e = sb_q.pop_front();
                check_eq("frame_data", {24'd0, frame_data}, {24'd0, e.data});
                check_eq("frame_mask", {24'd0, frame_mask}, {24'd0, e.mask});
                check_eq("frame_partial", {31'd0, frame_partial}, {31'd0, e.partial});
                check_eq("frame_cycle", cyc, e.cyc);
            end
        end
        prev_valid = frame_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] sel, input logic a);
        logic [7:0] v;
        v        = {7'd0, a};
        in_valid = 1'b1;
        in_sel   = sel;
        lane_in  = v << sel;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] m, input logic p, input int c);
        frame_t f;
        f.data = d; f.mask = m; f.partial = p; f.cyc = c;
        sb_q.push_back(f);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_outs"},
                 {22'd0, frame_valid, frame_partial, frame_data, frame_mask},
                 32'd0);
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, "_errs"}, {29'd0, err_mismatch, err_dup, err_overflow}, 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        int         n0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sel      = 3'd0;
        lane_in     = 8'd0;
        frame_ready = 1'b1;
        err_clr     = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();

        // 1: full frame, pattern B2
        a = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(8'hB2, 8'hFF, 1'b0, cyc + 1);
            write(3'(i), a[i]);
        end
        check_eq("t1_valid", {31'd0, frame_valid}, 32'd1);
        check_eq("t1_errs", {29'd0, err_mismatch, err_dup, err_overflow}, 32'd0);
        idle(2);

        // 2: back-pressure in HOLD with overflow attempts
        frame_ready = 1'b0;
        a = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(8'h5A, 8'hFF, 1'b0, cyc + 1);
            write(3'(i), a[i]);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_sel   = 3'd1;
            lane_in  = 8'hFF;
            step();
            check_eq("t2_hold", {22'd0, frame_valid, in_ready, frame_data}, {22'd0, 1'b1, 1'b0, 8'h5A});
        end
        check_eq("t2_overflow", {31'd0, err_overflow}, 32'd1);
        in_valid    = 1'b0;
        frame_ready = 1'b1;
        step();
        check_eq("t2_release", {22'd0, frame_valid, in_ready, frame_mask}, {22'd0, 1'b0, 1'b1, 8'h00});
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("t2_errclr", {31'd0, err_overflow}, 32'd0);

        // 3: timeout flush, then postponed flush
        push(8'h04, 8'h04, 1'b1, cyc + 17);
        write(3'd2, 1'b1);
        idle(20);
        n0 = cyc;
        write(3'd2, 1'b1);
        idle(14);
        check_eq("t3_no_early_flush", {31'd0, frame_valid}, 32'd0);
        push(8'h04, 8'h0C, 1'b1, cyc + 17);
        check_eq("t3_write_offset", cyc - n0, 32'd15);
        write(3'd3, 1'b0);
        idle(20);

        // 4: mismatch and err_clr priority
        in_valid = 1'b1; in_sel = 3'd3; lane_in = 8'h18;
        step();
        check_eq("t4_mismatch", {30'd0, err_mismatch, frame_data[3]}, 32'd3);
        in_valid = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("t4_cleared", {31'd0, err_mismatch}, 32'd0);
        in_valid = 1'b1; in_sel = 3'd4; lane_in = 8'h30;
        step();
        check_eq("t4_reset_again", {31'd0, err_mismatch}, 32'd1);
        push(8'h38, 8'h38, 1'b1, cyc + 17);
        in_sel = 3'd5; lane_in = 8'h60; err_clr = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b0;
        check_eq("t4_set_wins", {31'd0, err_mismatch}, 32'd1);
        idle(20);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // 5: duplicate lane overwrite
        write(3'd5, 1'b1);
        push(8'h00, 8'h20, 1'b1, cyc + 17);
        write(3'd5, 1'b0);
        check_eq("t5_dup", {29'd0, err_dup, frame_data[5], frame_mask[5]}, {29'd0, 3'b101});
        check_eq("t5_no_mismatch", {31'd0, err_mismatch}, 32'd0);
        idle(20);

        // 6: reset mid-COLLECT and mid-HOLD
        for (int i = 0; i < 4; i++) write(3'(i), 1'b1);
        write(3'd0, 1'b1);
        check_eq("t6_mask", {24'd0, frame_mask}, 32'h0F);
        rst_n = 1'b0;
        step();
        check_reset_state("t6_collect_rst");
        rst_n = 1'b1;
        idle(20);
        frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(8'hFF, 8'hFF, 1'b0, cyc + 1);
            write(3'(i), 1'b1);
        end
        check_eq("t6_hold", {31'd0, frame_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        check_reset_state("t6_hold_rst");
        rst_n       = 1'b1;
        frame_ready = 1'b1;
        idle(5);
        check_eq("t6_no_frame", {31'd0, frame_valid}, 32'd0);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
